// File: rtl/teclado_pkg.sv
// Shared types and helpers for the keypad scanner: FSM state encoding,
// lowest-set-index and multi-key detection over a key pattern (up to MAX_KEYS lines).
package teclado_pkg;

  localparam int MAX_KEYS = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  function automatic int unsigned lowest_set_idx(input logic [MAX_KEYS-1:0] pat);
    int unsigned idx;
    logic        found;
    idx   = 32'd0;
    found = 1'b0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      if (!found && pat[i]) begin
        idx   = unsigned'(i);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only when two or more bits were set.
  function automatic logic multi_set(input logic [MAX_KEYS-1:0] pat);
    return |(pat & (pat - {{(MAX_KEYS-1){1'b0}}, 1'b1}));
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/teclado_sync.sv
// Parametrised-width two-flop synchroniser with synchronous reset to zero.
module teclado_sync #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  // metastability filter stages
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= {WIDTH{1'b0}};
      r_s2 <= {WIDTH{1'b0}};
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/teclado_scan.sv
// Keypad front-end: synchronise, debounce and priority-encode key lines into
// single valid/ack events. Optional auto-repeat while held: TECLADO_REPEAT_EN.
module teclado_scan
  import teclado_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int CODE_W          = $clog2(N_KEYS),
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int REPEAT_CYCLES   = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] keys_in,
  input  logic              key_ack,
  output logic              key_valid,
  output logic [CODE_W-1:0] key_code,
  output logic              key_multi,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_MAX = max_int(DEBOUNCE_CYCLES, REPEAT_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_KEYS-1:0] KEYS_NONE = {N_KEYS{1'b0}};
`ifdef TECLADO_REPEAT_EN
  localparam logic [CNT_W-1:0]  REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic [N_KEYS-1:0] w_ks;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [N_KEYS-1:0] r_pat;
  logic [N_KEYS-1:0] w_pat_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_event;
  logic [CODE_W-1:0] w_ev_code;
  logic              w_ev_multi;

  logic              r_valid;
  logic [CODE_W-1:0] r_code;
  logic              r_multi;
  logic              r_overrun;
  logic              r_busy;

  teclado_sync #(
    .WIDTH (N_KEYS)
  ) u_sync (
    .i_clk (clk),
    .i_rst (rst),
    .i_d   (keys_in),
    .o_q   (w_ks)
  );

  assign w_cnt_inc  = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  assign w_ev_code  = CODE_W'(lowest_set_idx(MAX_KEYS'(r_pat)));
  assign w_ev_multi = multi_set(MAX_KEYS'(r_pat));

  // state, latched pattern and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_pat   <= KEYS_NONE;
      r_cnt   <= CNT_ZERO;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pat   <= w_pat_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  // next-state, counter and event decode
  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_cnt_nxt   = r_cnt;
    w_event     = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = CNT_ZERO;
        if (w_ks != KEYS_NONE) begin
          w_pat_nxt   = w_ks;
          w_state_nxt = DEBOUNCE;
        end else begin
          w_pat_nxt = r_pat;
        end
      end
      DEBOUNCE: begin
        if (w_ks == KEYS_NONE) begin
          w_cnt_nxt   = CNT_ZERO;
          w_state_nxt = IDLE;
        end else if (w_ks != r_pat) begin
          w_pat_nxt = w_ks;
          w_cnt_nxt = CNT_ZERO;
        end else if (r_cnt == DEB_LAST) begin
          w_event     = 1'b1;
          w_cnt_nxt   = CNT_ZERO;
          w_state_nxt = PRESSED;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      PRESSED: begin
        if (w_ks == KEYS_NONE) begin
          w_cnt_nxt   = CNT_ZERO;
          w_state_nxt = RELEASE;
        end else if (w_ks != r_pat) begin
          // a changed chord while held never produces an event by itself
          w_pat_nxt = w_ks;
          w_cnt_nxt = CNT_ZERO;
        end else begin
`ifdef TECLADO_REPEAT_EN
          if (r_cnt == REP_LAST) begin
            w_event   = 1'b1;
            w_cnt_nxt = CNT_ZERO;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
`else
          w_cnt_nxt = CNT_ZERO;
`endif
        end
      end
      RELEASE: begin
        if (w_ks != KEYS_NONE) begin
          w_pat_nxt   = w_ks;
          w_cnt_nxt   = CNT_ZERO;
          w_state_nxt = PRESSED;
        end else if (r_cnt == DEB_LAST) begin
          w_cnt_nxt   = CNT_ZERO;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_pat_nxt   = KEYS_NONE;
        w_cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // event delivery: a pending unacked event is never overwritten
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_code    <= {CODE_W{1'b0}};
      r_multi   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_event && r_valid && !key_ack) begin
      r_overrun <= 1'b1;
    end else if (w_event) begin
      r_valid   <= 1'b1;
      r_code    <= w_ev_code;
      r_multi   <= w_ev_multi;
      r_overrun <= 1'b0;
    end else if (r_valid && key_ack) begin
      r_valid   <= 1'b0;
      r_multi   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= r_valid;
    end
  end

  assign key_valid = r_valid;
  assign key_code  = r_code;
  assign key_multi = r_multi;
  assign overrun   = r_overrun;
  assign busy      = r_busy;

endmodule

// File: tb/tb_teclado_scan.sv
// Directed self-checking bench for teclado_scan (N_KEYS=4, DEBOUNCE_CYCLES=4,
// REPEAT_CYCLES=8); repeat expectations switch on TECLADO_REPEAT_EN.
module tb_teclado_scan;

  logic       clk;
  logic       rst;
  logic [3:0] keys_in;
  logic       key_ack;
  logic       key_valid;
  logic [1:0] key_code;
  logic       key_multi;
  logic       overrun;
  logic       busy;

  int n_checks;
  int n_errors;

  teclado_scan #(
    .N_KEYS          (4),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .keys_in   (keys_in),
    .key_ack   (key_ack),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_multi (key_multi),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then settle before sampling/driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    tick();
    key_ack = 1'b0;
  endtask

  task automatic release_keys();
    keys_in = 4'b0000;
    repeat (12) tick();
    chk("idle_after_release", 32'(busy), 32'd0);
  endtask

  initial begin
    logic exp_v;
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    keys_in  = 4'b0000;
    key_ack  = 1'b0;
    tick();
    tick();
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_multi", 32'(key_multi), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // single key 0100: event on the 7th edge, ack two cycles later
    keys_in = 4'b0100;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("t1_early", 32'(key_valid), 32'd0);
    end
    tick();
    chk("t1_valid", 32'(key_valid), 32'd1);
    chk("t1_code", 32'(key_code), 32'd2);
    chk("t1_multi", 32'(key_multi), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_hold", 32'(key_valid), 32'd1);
    ack_pulse();
    chk("t1_ack_clear", 32'(key_valid), 32'd0);
    for (int i = 10; i <= 20; i++) begin
      tick();
`ifdef TECLADO_REPEAT_EN
      exp_v = (i >= 15);
`else
      exp_v = 1'b0;
`endif
      chk("t1_no_second", 32'(key_valid), 32'(exp_v));
    end
    release_keys();
    // ack while nothing is pending must be ignored (clears a repeat if one fired)
    ack_pulse();
    chk("t1_idle_ack", 32'(key_valid), 32'd0);
    chk("t1_idle_ovr", 32'(overrun), 32'd0);

    // bounce: 0010 x2, 0 x1, then 0010 held
    keys_in = 4'b0010;
    tick();
    tick();
    keys_in = 4'b0000;
    tick();
    keys_in = 4'b0010;
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("t2_early", 32'(key_valid), 32'd0);
    end
    tick();
    chk("t2_valid", 32'(key_valid), 32'd1);
    chk("t2_code", 32'(key_code), 32'd1);
    ack_pulse();
    chk("t2_ack_clear", 32'(key_valid), 32'd0);
    repeat (3) begin
      tick();
      chk("t2_single", 32'(key_valid), 32'd0);
    end
    release_keys();

    // chord 1010
    keys_in = 4'b1010;
    repeat (7) tick();
    chk("t3_valid", 32'(key_valid), 32'd1);
    chk("t3_code", 32'(key_code), 32'd1);
    chk("t3_multi", 32'(key_multi), 32'd1);
    ack_pulse();
    chk("t3_multi_clear", 32'(key_multi), 32'd0);
    release_keys();

    // reset mid-debounce with 0100 held
    keys_in = 4'b0100;
    repeat (4) tick();
    chk("t5_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_valid", 32'(key_valid), 32'd0);
    chk("t5_code", 32'(key_code), 32'd0);
    chk("t5_multi", 32'(key_multi), 32'd0);
    chk("t5_overrun", 32'(overrun), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    for (int i = 1; i <= 6; i++) begin
      tick();
      chk("t5_early", 32'(key_valid), 32'd0);
    end
    tick();
    chk("t5_event", 32'(key_valid), 32'd1);
    chk("t5_code_ev", 32'(key_code), 32'd2);
    ack_pulse();
    release_keys();

    // overrun: 0001 left unacked, then 1000 pressed
    keys_in = 4'b0001;
    repeat (7) tick();
    chk("t4_valid", 32'(key_valid), 32'd1);
    chk("t4_code", 32'(key_code), 32'd0);
    release_keys();
    chk("t4_pending", 32'(key_valid), 32'd1);
    chk("t4_no_ovr", 32'(overrun), 32'd0);
    keys_in = 4'b1000;
    repeat (6) tick();
    chk("t4_ovr_early", 32'(overrun), 32'd0);
    tick();
    chk("t4_overrun", 32'(overrun), 32'd1);
    chk("t4_code_kept", 32'(key_code), 32'd0);
    chk("t4_valid_kept", 32'(key_valid), 32'd1);
    ack_pulse();
    chk("t4_ack_valid", 32'(key_valid), 32'd0);
    chk("t4_ack_ovr", 32'(overrun), 32'd0);
    release_keys();

    // long hold of 0001, acking each event immediately; the release reaches
    // the FSM two edges late, so a repeat due on edge 31 still fires
    keys_in = 4'b0001;
    for (int t = 1; t <= 50; t++) begin
      tick();
      if (t == 30) keys_in = 4'b0000;
`ifdef TECLADO_REPEAT_EN
      exp_v = (t == 7) || (t == 15) || (t == 23) || (t == 31);
`else
      exp_v = (t == 7);
`endif
      chk("t6_events", 32'(key_valid), 32'(exp_v));
      if (exp_v) chk("t6_code", 32'(key_code), 32'd0);
      key_ack = exp_v;
    end
    key_ack = 1'b0;
    chk("t6_no_ovr", 32'(overrun), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/teclado_scan.md
# teclado_scan

Parametrised keypad front-end for the vending-machine controller: synchronises N raw key lines, debounces them, and priority-encodes the winning key into a binary code. Each qualified press is delivered to the downstream vending FSM as a single event over a valid/ack handshake, with multi-key and overrun flags. It replaces the combinational key encoder between the physical keypad and the credit/selection logic.

## Interface
- N_KEYS, 4, number of key lines (≥2)
- CODE_W, $clog2(N_KEYS), width of key_code
- DEBOUNCE_CYCLES, 1000, consecutive stable cycles required for press and for release (≥2)
- REPEAT_CYCLES, 50000, hold period between auto-repeat events (used only with TECLADO_REPEAT_EN)
- clk  in  1  single system clock, rising edge
- rst  in  1  synchronous, active-high reset
- keys_in  in  N_KEYS  raw asynchronous key lines, 1 = pressed
- key_ack  in  1  consumer accepts the pending event
- key_valid  out  1  event pending; held until acked
- key_code  out  CODE_W  index of the pressed key, lowest set index wins
- key_multi  out  1  more than one key was set when the event qualified
- overrun  out  1  sticky; an event was dropped while key_valid was high
- busy  out  1  FSM not in IDLE

## Operation
- 2-flop synchroniser on keys_in, giving `ks`.
- FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE.
- IDLE: ks ≠ 0 → latch pattern, clear counter, go to DEBOUNCE.
- DEBOUNCE: ks equal to latched pattern → counter increments. ks changes to another nonzero pattern → re-latch and clear counter. ks = 0 → IDLE. Counter reaches DEBOUNCE_CYCLES−1 → generate event, go to PRESSED.
- PRESSED: ks = 0 → clear counter, go to RELEASE. Pattern changes while still nonzero → no new event.
- RELEASE: ks stays 0 for DEBOUNCE_CYCLES → IDLE. Any nonzero ks → back to PRESSED, no event.
- Event generation:
  - key_code = lowest set index of the latched pattern.
  - key_multi = popcount > 1.
  - key_valid set.
- Handshake:
  - key_ack sampled with key_valid high → key_valid, key_multi and overrun clear next cycle.
  - key_ack with key_valid low is ignored.
- Event while key_valid high and no ack in the same cycle: key_code and key_multi keep their old values; overrun is set.
- Event and ack in the same cycle: the new event is loaded, key_valid stays high, overrun is not set.
- Reset values: key_valid, key_code, key_multi, overrun, busy, counter and synchronisers all 0; state IDLE.
- rst in any state takes effect at the next edge. A key still held after reset re-debounces from scratch.

## Timing
- Press latency: first edge sampling a stable keys_in → key_valid high after DEBOUNCE_CYCLES+3 edges (2 sync + DEBOUNCE_CYCLES + 1 output register).
- Minimum press-to-press spacing: press debounce, plus 1 cycle into RELEASE, plus DEBOUNCE_CYCLES of release.
- Ack-to-clear: 1 cycle.
- All outputs are registered; there is no combinational path from keys_in or key_ack to outputs.
- Counter width: $clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)+1). It saturates and never wraps.

## Configuration
- Macro: TECLADO_REPEAT_EN.
- Defined: in PRESSED, an unchanged nonzero pattern held REPEAT_CYCLES generates another event, with the same handshake and overrun rules. This repeats every REPEAT_CYCLES while held. A pattern change restarts the repeat counter.
- Undefined: exactly one event per press. REPEAT_CYCLES is ignored and its logic is absent.

## Structure
- Package teclado_pkg holds:
  - state enum (IDLE, DEBOUNCE, PRESSED, RELEASE)
  - lowest-set-index function
  - popcount>1 function
- Sub-module teclado_sync: parametrised-width 2-flop synchroniser with synchronous reset to 0.
- Counter, FSM and output/handshake registers stay in teclado_scan.

## Test plan
Bench configuration: N_KEYS=4, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.
- keys_in=4'b0100 held 20 cycles, ack 2 cycles after valid → key_valid high 7 cycles after first sample; key_code=2, key_multi=0; valid low 1 cycle after ack; no second event.
- keys_in=0010 for 2 cycles, 0 for 1 cycle, then 0010 held → exactly one event, key_code=1, valid 7 cycles after the final rising of the input.
- keys_in=1010 held → key_code=1, key_multi=1.
- Press 0001 (no ack), full release, press 1000 → overrun=1, key_code stays 0; ack clears key_valid and overrun together.
- rst pulsed 1 cycle mid-DEBOUNCE with 0100 held → all outputs 0 next cycle; event fires 7 cycles after rst deasserts.
- TECLADO_REPEAT_EN defined, 0001 held 30 cycles, ack each event immediately → first event at 7, repeats at 8-cycle spacing; none after release.
